// File: rtl/clm_decode_seq.sv
// Sequential CLM decoder: multiplies each of 16 latched (8+d)-bit codewords by
// a latched GF(2) inverse matrix, one byte per cycle, with valid/ready on both sides.
module clm_decode_seq #(
    parameter int unsigned d = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0][8+d-1:0]      enc_in,
    input  logic [8+d-1:0][8+d-1:0]   Minv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0][7:0]          out_data,
    output logic [15:0][d-1:0]        out_r
);

    localparam int unsigned N = 8 + d;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [15:0][N-1:0]     enc_q;
    logic [N-1:0][N-1:0]    minv_q;
    logic [3:0]             cnt_q;
    logic [N-1:0]           cw;
    logic [N-1:0]           dec;
    logic                   accept_c;
    logic                   step_c;
    logic                   release_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == 4'd15) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and datapath strobes decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        accept_c  = 1'b0;
        step_c    = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept_c = in_valid;
            end
            RUN:     step_c    = 1'b1;
            DONE:    release_c = out_ready;
            default: ;
        endcase
    end

    // Matrix-vector product over GF(2) for the current byte
    always_comb begin
        cw  = enc_q[cnt_q];
        dec = '0;
        for (int i = 0; i < int'(N); i++) begin
            dec[i] = ^(cw & minv_q[i]);
        end
    end

    // Input latches, byte counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_q     <= '0;
            minv_q    <= '0;
            cnt_q     <= 4'd0;
            out_data  <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                enc_q  <= enc_in;
                minv_q <= Minv;
                cnt_q  <= 4'd0;
            end
            if (step_c) begin
                out_data[cnt_q] <= dec[7:0];
                out_r[cnt_q]    <= dec[N-1:8];
                if (cnt_q == 4'd15) begin
                    out_valid <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
            if (release_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clm_decode_seq.sv
// Scoreboard bench for clm_decode_seq: directed blocks, back-pressure, reset
// abort, input churn during RUN and a random encode/decode round trip.
module tb_clm_decode_seq;

    localparam int unsigned D = 2;
    localparam int unsigned N = 10;

    typedef logic [15:0][N-1:0] enc_t;
    typedef logic [N-1:0][N-1:0] mat_t;
    typedef logic [15:0][7:0]   data_t;
    typedef logic [15:0][D-1:0] r_t;

    logic  clk;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    enc_t  enc_in;
    mat_t  Minv;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    r_t    out_r;

    int errors = 0;
    int checks = 0;

    data_t exp_data_q[$];
    r_t    exp_r_q[$];
    data_t mon_d;
    r_t    mon_r;

    enc_t  e;
    mat_t  m;
    mat_t  mi;
    data_t ed;
    r_t    er;
    int    lat;
    int    seen;

    clm_decode_seq #(.d(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_in    (enc_in),
        .Minv      (Minv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_r     (out_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mat_t ident();
        mat_t r;
        r = '0;
        for (int i = 0; i < int'(N); i++) r[i][i] = 1'b1;
        return r;
    endfunction

    // Monitor: pops an expected block on every output handshake
    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_output", 128'd1, 128'd0);
            end else begin
                mon_d = exp_data_q.pop_front();
                mon_r = exp_r_q.pop_front();
                check("block_data", out_data, mon_d);
                check("block_r", 128'(out_r), 128'(mon_r));
            end
        end
    end

    task automatic send(input enc_t be, input mat_t bm, input data_t bd, input r_t br, input bit push);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 128'd0, 128'd1);
        enc_in   = be;
        Minv     = bm;
        in_valid = 1'b1;
        if (push) begin
            exp_data_q.push_back(bd);
            exp_r_q.push_back(br);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_data_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("drain", 128'(exp_data_q.size()), 128'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enc_in    = '0;
        Minv      = '0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_r", 128'(out_r), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Identity matrix, k*17 with randomness k mod 4, plus latency
        for (int k = 0; k < 16; k++) begin
            e[k]  = {2'(k % 4), 8'(k * 17)};
            ed[k] = 8'(k * 17);
            er[k] = 2'(k % 4);
        end
        send(e, ident(), ed, er, 1'b1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", 128'(lat), 128'd16);
        drain();

        // Row 0 all ones: bit 0 becomes parity of the whole codeword
        m    = ident();
        m[0] = '1;
        e    = '0;
        ed   = '0;
        er   = '0;
        e[0]  = 10'h001;
        ed[0] = 8'h01;
        send(e, m, ed, er, 1'b1);
        e[0]  = 10'h003;
        ed[0] = 8'h02;
        send(e, m, ed, er, 1'b1);
        drain();

        // Back-pressure: outputs hold, in_ready low, extra in_valid ignored
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e[k]  = {2'(3 - k % 4), 8'(255 - k * 17)};
            ed[k] = 8'(255 - k * 17);
            er[k] = 2'(3 - k % 4);
        end
        send(e, ident(), ed, er, 1'b1);
        for (int w = 0; w < 40 && !out_valid; w++) @(negedge clk);
        check("bp_valid_rise", 128'(out_valid), 128'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            enc_in   = '1;
            #1;
            check("bp_valid_hold", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_data_hold", out_data, ed);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 128'(in_ready), 128'd1);
        check("bp_release_valid", 128'(out_valid), 128'd0);
        for (int k = 0; k < 16; k++) begin
            e[k]  = {2'(k % 4), 8'(k + 100)};
            ed[k] = 8'(k + 100);
            er[k] = 2'(k % 4);
        end
        send(e, ident(), ed, er, 1'b1);
        drain();

        // Inputs churn during RUN; result follows the values latched at accept
        for (int k = 0; k < 16; k++) begin
            e[k]  = {2'((k + 1) % 4), 8'(k * 5)};
            ed[k] = 8'(k * 5);
            er[k] = 2'((k + 1) % 4);
        end
        send(e, ident(), ed, er, 1'b1);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) enc_in[k] = N'($urandom);
            for (int i = 0; i < int'(N); i++) Minv[i] = N'($urandom);
        end
        drain();

        // Reset in the middle of RUN discards the block
        send(e, ident(), ed, er, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_data", out_data, 128'd0);
        check("midrst_out_r", 128'(out_r), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 128'(in_ready), 128'd1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("postrst_no_valid", 128'(seen), 128'd0);
        for (int k = 0; k < 16; k++) begin
            e[k]  = {2'(k % 4), 8'(k * 17)};
            ed[k] = 8'(k * 17);
            er[k] = 2'(k % 4);
        end
        send(e, ident(), ed, er, 1'b1);
        drain();

        // Random invertible M built from row additions; Minv tracked by column additions
        for (int b = 0; b < 1000; b++) begin
            m  = ident();
            mi = ident();
            repeat (40) begin
                int a;
                int c;
                a = int'($urandom_range(0, N - 1));
                c = int'($urandom_range(0, N - 1));
                if (a != c) begin
                    m[a] = m[a] ^ m[c];
                    for (int i = 0; i < int'(N); i++) begin
                        if (mi[i][a]) mi[i][c] = ~mi[i][c];
                    end
                end
            end
            for (int k = 0; k < 16; k++) begin
                logic [7:0]   bt;
                logic [D-1:0] rr;
                logic [N-1:0] x;
                bt = 8'($urandom);
                rr = D'($urandom);
                x  = {rr, bt};
                for (int i = 0; i < int'(N); i++) e[k][i] = ^(m[i] & x);
                ed[k] = bt;
                er[k] = rr;
            end
            send(e, mi, ed, er, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
